// File: rtl/de_add_key_mix.sv
// AddRoundKey followed by InvMixColumns on a 128-bit AES state.
// The mix is applied COLS_PER_CYC columns per cycle.
module de_add_key_mix #(
    parameter int unsigned COLS_PER_CYC = 1
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iValid,
    output logic         oReady,
    input  logic [127:0] iState,
    input  logic [127:0] iRoundKey,
    input  logic         iLastRound,
    output logic         oValid,
    input  logic         iReady,
    output logic [127:0] oState
);

    typedef enum logic [1:0] {StIdle, StMix, StDone} state_e;

    localparam logic [2:0] ColStep = 3'(COLS_PER_CYC);

    state_e        state_q, state_d;
    logic [127:0]  w_q, w_d;
    logic [1:0]    col_q, col_d;
    logic          last_q, last_d;
    logic [2:0]    col_next;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        return {mule(s0) ^ mulb(s1) ^ muld(s2) ^ mul9(s3),
                mul9(s0) ^ mule(s1) ^ mulb(s2) ^ muld(s3),
                muld(s0) ^ mul9(s1) ^ mule(s2) ^ mulb(s3),
                mulb(s0) ^ muld(s1) ^ mul9(s2) ^ mule(s3)};
    endfunction

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        col_d    = col_q;
        last_d   = last_q;
        col_next = {1'b0, col_q} + ColStep;

        unique case (state_q)
            StIdle: begin
                if (iValid) begin
                    w_d     = iState ^ iRoundKey;
                    last_d  = iLastRound;
                    col_d   = 2'd0;
                    state_d = iLastRound ? StDone : StMix;
                end
            end
            StMix: begin
                // Column c lives at bits [127-32c -: 32]; counter is always a multiple of the step.
                if (!last_q) begin
                    for (int unsigned j = 0; j < COLS_PER_CYC; j++) begin
                        int unsigned idx;
                        idx = 32'(col_q) + j;
                        w_d[(3 - idx) * 32 +: 32] = inv_mix_col(w_q[(3 - idx) * 32 +: 32]);
                    end
                end
                col_d = col_next[1:0];
                if (col_next[2]) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (iReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= StIdle;
            w_q     <= '0;
            col_q   <= 2'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            col_q   <= col_d;
            last_q  <= last_d;
        end
    end

    assign oReady = (state_q == StIdle);
    assign oValid = (state_q == StDone);
    assign oState = w_q;

endmodule

// File: tb/tb_de_add_key_mix.sv
// Randomized bench for de_add_key_mix: one instance per mix width, checked against
// a matrix-multiply model of InvMixColumns using generic GF(2^8) multiplication.
module tb_de_add_key_mix;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   vin, rin, rdy_o, vout;
    logic [127:0] st, key;
    logic         last;
    logic [127:0] ost [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    de_add_key_mix #(.COLS_PER_CYC(1)) u_dut1 (
        .iClk(clk), .iRst_n(rst_n), .iValid(vin[0]), .oReady(rdy_o[0]),
        .iState(st), .iRoundKey(key), .iLastRound(last),
        .oValid(vout[0]), .iReady(rin[0]), .oState(ost[0])
    );

    de_add_key_mix #(.COLS_PER_CYC(4)) u_dut4 (
        .iClk(clk), .iRst_n(rst_n), .iValid(vin[1]), .oReady(rdy_o[1]),
        .iState(st), .iRoundKey(key), .iLastRound(last),
        .oValid(vout[1]), .iReady(rin[1]), .oState(ost[1])
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] w, input logic lst);
        logic [7:0]   m [4];
        logic [127:0] r;
        logic [7:0]   acc;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        if (lst) return w;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(m[(k - i + 4) % 4], w[127 - 32 * c - 8 * k -: 8]);
                end
                r[127 - 32 * c - 8 * i -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_txn(input int d, input logic [127:0] s, input logic [127:0] k,
                           input logic lst, input logic [127:0] exp_st, input int hold,
                           input string tag);
        int lat;
        int exp_lat;
        exp_lat = lst ? 1 : ((d == 0) ? 5 : 2);
        @(negedge clk);
        check_eq({tag, "_rdy"}, 128'(rdy_o[d]), 128'd1);
        st     = s;
        key    = k;
        last   = lst;
        vin[d] = 1'b1;
        rin[d] = 1'($urandom_range(0, 1));
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (vout[d]) break;
            vin[d] = 1'($urandom);
            st     = junk();
            key    = junk();
            last   = 1'($urandom);
            rin[d] = 1'($urandom);
        end
        rin[d] = 1'b0;
        check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check_eq({tag, "_data"}, ost[d], exp_st);
        for (int h = 0; h < hold; h++) begin
            vin[d] = 1'b1;
            st     = junk();
            last   = 1'($urandom);
            @(negedge clk);
            check_eq({tag, "_hold_data"}, ost[d], exp_st);
            check_eq({tag, "_hold_ctl"}, {126'd0, vout[d], rdy_o[d]}, 128'b10);
        end
        rin[d] = 1'b1;
        vin[d] = 1'b1;
        st     = junk();
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_release"}, {126'd0, vout[d], rdy_o[d]}, 128'b01);
        vin[d] = 1'b0;
        rin[d] = 1'b0;
    endtask

    localparam logic [127:0] VecIn  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VecOut = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] KeyK   = 128'h01234567_89abcdef_01234567_89abcdef;

    initial begin
        logic [127:0] rs, rk;
        logic         rl;
        int           rd;
        rst_n = 1'b0;
        vin   = '0;
        rin   = '0;
        st    = '0;
        key   = '0;
        last  = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_ctl", {126'd0, vout[d], rdy_o[d]}, 128'b01);
            check_eq("reset_data", ost[d], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(0, VecIn, 128'd0, 1'b0, VecOut, 0, "vec_mix");
        run_txn(0, 128'd0, {128{1'b1}}, 1'b1, {128{1'b1}}, 1, "vec_last");
        run_txn(0, VecIn ^ KeyK, KeyK, 1'b0, VecOut, 0, "vec_key");
        run_txn(0, VecIn, 128'd0, 1'b0, VecOut, 3, "vec_backpressure");
        run_txn(1, VecIn, 128'd0, 1'b0, VecOut, 0, "vec_cols4");
        run_txn(1, 128'd0, {128{1'b1}}, 1'b1, {128{1'b1}}, 2, "vec_cols4_last");

        // Reset while the single-column instance is about to mix column 2.
        @(negedge clk);
        st     = VecIn;
        key    = 128'd0;
        last   = 1'b0;
        vin[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vin[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midmix_reset_ctl", {126'd0, vout[0], rdy_o[0]}, 128'b01);
        check_eq("midmix_reset_data", ost[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, VecIn ^ KeyK, KeyK, 1'b0, VecOut, 0, "after_reset");

        for (int n = 0; n < 40; n++) begin
            rs = junk();
            rk = junk();
            rl = ($urandom_range(0, 3) == 0);
            rd = int'($urandom_range(0, 1));
            run_txn(rd, rs, rk, rl, model(rs ^ rk, rl), int'($urandom_range(0, 4)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
